// File: rtl/jt51_pg_regs.sv
// Phase-generator register file: a 32-slot sweep presents per-slot and per-channel settings, with all outputs registered on cen.
// A data write is captured at once and commits on the next cen; busy then blocks further data writes for 32 cen pulses.
module jt51_pg_regs (
   input  logic       clk,
   input  logic       rst,
   input  logic       cen,
   input  logic       wr,
   input  logic       a0,
   input  logic [7:0] din,
   output logic       busy,
   output logic       zero,
   output logic [4:0] cnt_I,
   output logic [6:0] kc_I,
   output logic [5:0] kf_I,
   output logic [2:0] pms_I,
   output logic [1:0] dt2_I,
   output logic [2:0] dt1_II,
   output logic [3:0] mul_VI
);

   logic [4:0] cnt_q, cnt_d;
   logic [7:0] addr_q, addr_d;
   logic       pend_vld_q, pend_vld_d;
   logic [7:0] pend_addr_q, pend_addr_d;
   logic [7:0] pend_dat_q, pend_dat_d;
   logic [5:0] busy_cnt_q, busy_cnt_d;

   logic [2:0] dt1_q [32];
   logic [2:0] dt1_d [32];
   logic [3:0] mul_q [32];
   logic [3:0] mul_d [32];
   logic [1:0] dt2_q [32];
   logic [1:0] dt2_d [32];
   logic [6:0] kc_q  [8];
   logic [6:0] kc_d  [8];
   logic [5:0] kf_q  [8];
   logic [5:0] kf_d  [8];
   logic [2:0] pms_q [8];
   logic [2:0] pms_d [8];

   logic [6:0] kc_out_q, kc_out_d;
   logic [5:0] kf_out_q, kf_out_d;
   logic [2:0] pms_out_q, pms_out_d;
   logic [1:0] dt2_out_q, dt2_out_d;
   logic [2:0] dt1_out_q, dt1_out_d;
   logic [3:0] mul_out_q, mul_out_d;

   logic       accept;
   logic [4:0] cnt_nx;
   logic [4:0] slot_vi;

   assign accept  = wr & a0 & (busy_cnt_q == 6'd0);
   assign cnt_nx  = cnt_q + 5'd1;
   assign slot_vi = cnt_nx - 5'd5;

   always_comb begin
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      pend_vld_d  = pend_vld_q;
      pend_addr_d = pend_addr_q;
      pend_dat_d  = pend_dat_q;
      busy_cnt_d  = busy_cnt_q;
      dt1_d       = dt1_q;
      mul_d       = mul_q;
      dt2_d       = dt2_q;
      kc_d        = kc_q;
      kf_d        = kf_q;
      pms_d       = pms_q;
      kc_out_d    = kc_out_q;
      kf_out_d    = kf_out_q;
      pms_out_d   = pms_out_q;
      dt2_out_d   = dt2_out_q;
      dt1_out_d   = dt1_out_q;
      mul_out_d   = mul_out_q;

      if (wr && !a0) addr_d = din;

      if (cen) begin
         cnt_d = cnt_nx;
         // Outputs read storage before this edge's commit, so a slot never changes mid-visit.
         kc_out_d  = kc_q[cnt_nx[2:0]];
         kf_out_d  = kf_q[cnt_nx[2:0]];
         pms_out_d = pms_q[cnt_nx[2:0]];
         dt2_out_d = dt2_q[cnt_nx];
         dt1_out_d = dt1_q[cnt_q];
         mul_out_d = mul_q[slot_vi];
         if (busy_cnt_q != 6'd0) busy_cnt_d = busy_cnt_q - 6'd1;
         if (pend_vld_q) begin
            pend_vld_d = 1'b0;
            if (pend_addr_q[7:3] == 5'b00101) kc_d[pend_addr_q[2:0]] = pend_dat_q[6:0];
            if (pend_addr_q[7:3] == 5'b00110) kf_d[pend_addr_q[2:0]] = pend_dat_q[7:2];
            if (pend_addr_q[7:3] == 5'b00111) pms_d[pend_addr_q[2:0]] = pend_dat_q[6:4];
            if (pend_addr_q[7:5] == 3'b010) begin
               dt1_d[pend_addr_q[4:0]] = pend_dat_q[6:4];
               mul_d[pend_addr_q[4:0]] = pend_dat_q[3:0];
            end
            if (pend_addr_q[7:5] == 3'b110) dt2_d[pend_addr_q[4:0]] = pend_dat_q[7:6];
         end
      end

      // Unmapped addresses still load the busy counter; decode only matters at commit.
      if (accept) begin
         pend_vld_d  = 1'b1;
         pend_addr_d = addr_q;
         pend_dat_d  = din;
         busy_cnt_d  = 6'd32;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q       <= '0;
         addr_q      <= '0;
         pend_vld_q  <= 1'b0;
         pend_addr_q <= '0;
         pend_dat_q  <= '0;
         busy_cnt_q  <= '0;
         for (int i = 0; i < 32; i++) begin
            dt1_q[i] <= '0;
            mul_q[i] <= '0;
            dt2_q[i] <= '0;
         end
         for (int i = 0; i < 8; i++) begin
            kc_q[i]  <= '0;
            kf_q[i]  <= '0;
            pms_q[i] <= '0;
         end
         kc_out_q  <= '0;
         kf_out_q  <= '0;
         pms_out_q <= '0;
         dt2_out_q <= '0;
         dt1_out_q <= '0;
         mul_out_q <= '0;
      end else begin
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         pend_vld_q  <= pend_vld_d;
         pend_addr_q <= pend_addr_d;
         pend_dat_q  <= pend_dat_d;
         busy_cnt_q  <= busy_cnt_d;
         dt1_q       <= dt1_d;
         mul_q       <= mul_d;
         dt2_q       <= dt2_d;
         kc_q        <= kc_d;
         kf_q        <= kf_d;
         pms_q       <= pms_d;
         kc_out_q    <= kc_out_d;
         kf_out_q    <= kf_out_d;
         pms_out_q   <= pms_out_d;
         dt2_out_q   <= dt2_out_d;
         dt1_out_q   <= dt1_out_d;
         mul_out_q   <= mul_out_d;
      end
   end

   assign busy   = (busy_cnt_q != 6'd0);
   assign zero   = (cnt_q == 5'd0);
   assign cnt_I  = cnt_q;
   assign kc_I   = kc_out_q;
   assign kf_I   = kf_out_q;
   assign pms_I  = pms_out_q;
   assign dt2_I  = dt2_out_q;
   assign dt1_II = dt1_out_q;
   assign mul_VI = mul_out_q;

endmodule

// File: tb/tb_jt51_pg_regs.sv
// Scoreboard bench for jt51_pg_regs: stimulus pushes predicted outputs per cen, a monitor pops and compares after each cen edge.
module tb_jt51_pg_regs;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cen = 1'b0;
   logic       wr  = 1'b0;
   logic       a0  = 1'b0;
   logic [7:0] din = 8'h00;
   logic       busy, zero;
   logic [4:0] cnt_I;
   logic [6:0] kc_I;
   logic [5:0] kf_I;
   logic [2:0] pms_I;
   logic [1:0] dt2_I;
   logic [2:0] dt1_II;
   logic [3:0] mul_VI;

   jt51_pg_regs dut (
      .clk(clk), .rst(rst), .cen(cen), .wr(wr), .a0(a0), .din(din),
      .busy(busy), .zero(zero), .cnt_I(cnt_I), .kc_I(kc_I), .kf_I(kf_I),
      .pms_I(pms_I), .dt2_I(dt2_I), .dt1_II(dt1_II), .mul_VI(mul_VI)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0] cnt;
      logic       zero;
      logic       busy;
      logic [6:0] kc;
      logic [5:0] kf;
      logic [2:0] pms;
      logic [1:0] dt2;
      logic [2:0] dt1;
      logic [3:0] mul;
   } exp_t;

   exp_t exp_q[$];
   exp_t exp_last;
   int   checks = 0;
   int   errors = 0;

   // Reference state, updated from the directed writes by the address map alone.
   logic [4:0] cnt_m;
   int         busy_m;
   logic       pend_m;
   logic [7:0] addr_m, paddr_m, pdat_m;
   logic [2:0] dt1_m [32];
   logic [3:0] mul_m [32];
   logic [1:0] dt2_m [32];
   logic [6:0] kc_m  [8];
   logic [5:0] kf_m  [8];
   logic [2:0] pms_m [8];

   function automatic exp_t sample();
      exp_t a;
      a.cnt = cnt_I; a.zero = zero; a.busy = busy; a.kc = kc_I; a.kf = kf_I;
      a.pms = pms_I; a.dt2 = dt2_I; a.dt1 = dt1_II; a.mul = mul_VI;
      return a;
   endfunction

   task automatic chk(input string name, input exp_t act, input exp_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got cnt=%0d zero=%0b busy=%0b kc=%h kf=%h pms=%h dt2=%h dt1=%h mul=%h, expected cnt=%0d zero=%0b busy=%0b kc=%h kf=%h pms=%h dt2=%h dt1=%h mul=%h",
                  name, act.cnt, act.zero, act.busy, act.kc, act.kf, act.pms, act.dt2, act.dt1, act.mul,
                  exp.cnt, exp.zero, exp.busy, exp.kc, exp.kf, exp.pms, exp.dt2, exp.dt1, exp.mul);
      end
   endtask

   task automatic model_clear();
      cnt_m = '0; busy_m = 0; pend_m = 1'b0; addr_m = '0; paddr_m = '0; pdat_m = '0;
      for (int i = 0; i < 32; i++) begin dt1_m[i] = '0; mul_m[i] = '0; dt2_m[i] = '0; end
      for (int i = 0; i < 8; i++) begin kc_m[i] = '0; kf_m[i] = '0; pms_m[i] = '0; end
   endtask

   task automatic model_commit();
      logic [2:0] ch;
      logic [4:0] s;
      ch = paddr_m[2:0];
      s  = paddr_m[4:0];
      if (paddr_m inside {[8'h28:8'h2F]}) kc_m[ch] = pdat_m[6:0];
      else if (paddr_m inside {[8'h30:8'h37]}) kf_m[ch] = pdat_m[7:2];
      else if (paddr_m inside {[8'h38:8'h3F]}) pms_m[ch] = pdat_m[6:4];
      else if (paddr_m inside {[8'h40:8'h5F]}) begin dt1_m[s] = pdat_m[6:4]; mul_m[s] = pdat_m[3:0]; end
      else if (paddr_m inside {[8'hC0:8'hDF]}) dt2_m[s] = pdat_m[7:6];
   endtask

   // One cen pulse; the predicted post-edge outputs are queued before the edge.
   task automatic tick();
      exp_t e;
      logic [4:0] s1, s5;
      @(negedge clk);
      cen = 1'b1;
      cnt_m = cnt_m + 5'd1;
      s1 = cnt_m - 5'd1;
      s5 = cnt_m - 5'd5;
      e.cnt = cnt_m; e.zero = (cnt_m == 5'd0);
      e.kc = kc_m[cnt_m[2:0]]; e.kf = kf_m[cnt_m[2:0]]; e.pms = pms_m[cnt_m[2:0]];
      e.dt2 = dt2_m[cnt_m]; e.dt1 = dt1_m[s1]; e.mul = mul_m[s5];
      if (pend_m) begin model_commit(); pend_m = 1'b0; end
      if (busy_m > 0) busy_m--;
      e.busy = (busy_m != 0);
      exp_q.push_back(e);
      exp_last = e;
      @(negedge clk);
      cen = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wr_addr(input logic [7:0] a);
      @(negedge clk);
      wr = 1'b1; a0 = 1'b0; din = a;
      addr_m = a;
      @(negedge clk);
      wr = 1'b0;
   endtask

   task automatic wr_data(input logic [7:0] d);
      exp_t e;
      @(negedge clk);
      wr = 1'b1; a0 = 1'b1; din = d;
      if (busy_m == 0) begin busy_m = 32; pend_m = 1'b1; paddr_m = addr_m; pdat_m = d; end
      @(negedge clk);
      wr = 1'b0;
      e = exp_last;
      e.busy = (busy_m != 0);
      exp_last = e;
      chk("busy_after_write", sample(), e);
   endtask

   task automatic drain_busy();
      while (busy_m != 0) tick();
   endtask

   initial begin : monitor
      forever begin
         @(posedge clk);
         if (cen && !rst) begin
            #1;
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL scoreboard_underflow: got an output at cnt=%0d, expected none queued", cnt_I);
            end else begin
               chk("slot_outputs", sample(), exp_q.pop_front());
            end
         end
      end
   end

   initial begin : stim
      exp_t r;
      model_clear();
      r = '0; r.zero = 1'b1;
      exp_last = r;
      #12;
      chk("reset_state", sample(), r);
      @(negedge clk);
      rst = 1'b0;

      // kc on channel 3, then kf/pms on other channels
      ticks(3);
      wr_addr(8'h2B); wr_data(8'h4A);
      ticks(40);
      wr_addr(8'h31); wr_data(8'hFD);
      drain_busy();
      wr_addr(8'h3A); wr_data(8'h50);
      drain_busy();

      // dt1/mul on slot 5
      wr_addr(8'h45); wr_data(8'h37);
      ticks(36);

      // second data write 5 cen into busy is dropped
      wr_addr(8'h2E); wr_data(8'h11);
      ticks(5);
      wr_data(8'h22);
      drain_busy();
      ticks(34);

      // unmapped address: busy pulse only
      wr_addr(8'h10); wr_data(8'hFF);
      drain_busy();
      ticks(33);

      // cen held low mid-sweep, with a pending busy count
      wr_addr(8'hC7); wr_data(8'h80);
      ticks(13);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (i % 25 == 0) chk("cen_hold", sample(), exp_last);
      end
      chk("cen_hold_end", sample(), exp_last);
      drain_busy();
      ticks(33);

      // reset during busy aborts dt2 programming
      wr_addr(8'hC3); wr_data(8'hC0);
      ticks(10);
      @(negedge clk);
      rst = 1'b1;
      #2;
      r = '0; r.zero = 1'b1;
      chk("reset_in_busy", sample(), r);
      model_clear();
      exp_last = r;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("reset_release", sample(), r);
      ticks(33);

      @(negedge clk);
      @(negedge clk);
      if (exp_q.size() != 0) begin
         checks++; errors++;
         $display("FAIL scoreboard_leftover: got %0d queued, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no end of stimulus, expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/jt51_pg_regs.md
JT51_PG_REGS -- requirements
Module: jt51_pg_regs

Interface
REQ-001 The block SHALL have a single clock `clk` and an asynchronous, active-high reset `rst`.
REQ-002 Ports:
- `clk` — in, 1 — system clock.
- `rst` — in, 1 — asynchronous active-high reset.
- `cen` — in, 1 — clock enable; all state advances only when cen=1.
- `wr` — in, 1 — CPU write strobe, single `clk` cycle.
- `a0` — in, 1 — 0 = address write, 1 = data write.
- `din` — in, 8 — CPU write data.
- `busy` — out, 1 — data write in progress.
- `zero` — out, 1 — high while `cnt_I` = 0.
- `cnt_I` — out, 5 — slot index of stage-I outputs.
- `kc_I` — out, 7 — key code for slot `cnt_I`.
- `kf_I` — out, 6 — key fraction for slot `cnt_I`.
- `pms_I` — out, 3 — PM sensitivity for slot `cnt_I`.
- `dt2_I` — out, 2 — coarse detune for slot `cnt_I`.
- `dt1_II` — out, 3 — fine detune for slot `cnt_I`−1 mod 32.
- `mul_VI` — out, 4 — multiplier for slot `cnt_I`−5 mod 32.

Function
REQ-003 Slot counter: on each cen, `cnt_I` SHALL increment by 1, wrapping from 31 to 0.
REQ-004 Slot s = {op[1:0], ch[2:0]}.
- Per-slot storage SHALL hold dt1[2:0], mul[3:0] and dt2[1:0].
- Per-channel storage SHALL hold kc[6:0], kf[5:0] and pms[2:0].
REQ-005 Address write (wr=1, a0=0) SHALL latch din into an internal address register immediately, regardless of `busy` and `cen`.
REQ-006 A data write (wr=1, a0=1) with busy=0 SHALL be captured, and its register update SHALL become visible on the next cen.
REQ-007 Address decode for data writes:
- 0x28–0x2F: kc[ch] = din[6:0].
- 0x30–0x37: kf[ch] = din[7:2].
- 0x38–0x3F: pms[ch] = din[6:4].
- 0x40–0x5F: dt1[s] = din[6:4] and mul[s] = din[3:0], with s = addr[4:0].
- 0xC0–0xDF: dt2[s] = din[7:6].
- All other addresses: no storage change.
REQ-008 Channel outputs (`kc_I`, `kf_I`, `pms_I`) SHALL use ch = `cnt_I`[2:0].
REQ-009 All stage outputs SHALL be registered, updated on cen, and aligned to `cnt_I` as listed in REQ-002.
REQ-010 Busy timing:
- `busy` SHALL rise on the clk edge after an accepted data write, including writes to unmapped addresses.
- `busy` SHALL stay high for exactly 32 cen pulses, then fall.
REQ-011 A data write while busy=1 SHALL be dropped: no storage change and no busy extension.
REQ-012 If a write commits to the slot currently being presented, the new value SHALL appear on that slot's next visit, never mid-slot.
REQ-013 When cen=0 for any run of cycles, all outputs, the counter and the busy count SHALL hold their values.
REQ-014 Implementation constraints:
- Storage is register-based, 32 + 8 entries.
- No combinational path from `din`/`wr` to any output.

Reset
REQ-015 On rst=1, the following SHALL clear asynchronously to 0: all storage, `cnt_I`, the address register, the busy counter, and every output.
- With cnt_I=0 after reset, `zero` = 1.
REQ-016 Reset asserted during busy SHALL abort the pending write (no storage change if not yet committed) and force busy=0.
REQ-017 After rst falls, the first cen SHALL advance `cnt_I` to 1.

Verification
REQ-018 Write addr 0x2B then data 0x4A; run 40 cen.
- Expect `kc_I` = 0x4A whenever `cnt_I` ∈ {3, 11, 19, 27}, and 0 at other slots.
REQ-019 Write addr 0x45, data 0x37.
- Expect `dt1_II` = 3 when `cnt_I` = 6.
- Expect `mul_VI` = 7 when `cnt_I` = 10.
- Expect 0 for both at all other slots.
REQ-020 Data write, then a second data write 5 cen later.
- Expect busy high for exactly 32 cen.
- Expect the second value never to appear.
REQ-021 Write addr 0x10, data 0xFF.
- Expect busy pulse of 32 cen.
- Expect all outputs unchanged over a full 32-slot sweep.
REQ-022 Hold cen=0 for 100 clk mid-sweep.
- Expect outputs, `cnt_I` and busy frozen.
- Expect correct resumption afterwards.
REQ-023 Assert rst 10 cen into busy, after programming 0xC3 = 0xC0.
- Expect busy=0, `dt2_I` = 0 at all slots, `cnt_I` = 0 and zero=1.
